// File: rtl/cordic_pkg.sv
// Shared fixed-point definitions for the cordic/ cores: angle format, arctangent table, gain.
package cordic_pkg;

    localparam int ANG_W     = 32;
    localparam int ANG_FRAC  = 29;
    localparam int LUT_DEPTH = 32;
    localparam int LUT_IDX_W = 5;

    localparam logic [ANG_W-1:0] PI_Q329      = 32'h6487ED51;
    localparam logic [ANG_W-1:0] HALF_PI_Q329 = 32'h3243F6A9;

    // Limit of prod(sqrt(1 + 2^-2i)); 30 micro-rotations reach it to double precision.
    localparam real CORDIC_GAIN = 1.6467602581210656;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITERATE,
        ST_DONE
    } cordic_state_t;

    // atan(2^-i) in Q3.29, rounded to nearest.
    localparam logic [ANG_W-1:0] ATAN_LUT [LUT_DEPTH] = '{
        32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
        32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
        32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
        32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
        32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
        32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
        32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
        32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
    };

    function automatic logic [ANG_W-1:0] atan_lut(input logic [LUT_IDX_W-1:0] idx);
        return ATAN_LUT[idx];
    endfunction

    // Moves a non-negative Q3.29 constant onto a datapath with (29 + sh) fraction bits.
    function automatic logic [63:0] align_q329(input logic [ANG_W-1:0] v, input int sh);
        logic [63:0] wide;
        wide = {32'b0, v};
        if (sh >= 0) begin
            return wide << sh;
        end
        return wide >> (-sh);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: micro-rotation index -> atan(2^-i) on the internal angle grid.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic signed [W+1:0]  atan_val
);

    localparam int SH = W - 2 - ANG_FRAC;

    assign atan_val = signed'((W + 2)'(align_q329(atan_lut(idx), SH)));

endmodule

// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: atan2(y, x) in Q3.29 radians plus gain-scaled magnitude.
module cordic_atan2
    import cordic_pkg::*;
#(
    parameter int W    = 32,
    parameter int ITER = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                start,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    output logic                ready,
    output logic                done,
    output logic signed [W-1:0] angle,
    output logic signed [W+1:0] magnitude
);

    localparam int IW = W + 2;
    localparam logic [LUT_IDX_W-1:0] LAST = LUT_IDX_W'(ITER - 1);
    localparam logic signed [IW-1:0] HALF_PI_INT =
        signed'(IW'(align_q329(HALF_PI_Q329, W - 2 - ANG_FRAC)));

    cordic_state_t          state;
    logic [LUT_IDX_W-1:0]   iter_cnt;
    logic signed [IW-1:0]   x_r, y_r, z_r;
    logic                   zero_r;

    logic signed [IW-1:0]   x_ext, y_ext;
    logic signed [IW-1:0]   x_pre, y_pre, z_pre;
    logic signed [IW-1:0]   x_sh, y_sh;
    logic signed [IW-1:0]   x_nxt, y_nxt, z_nxt;
    logic signed [IW-1:0]   atan_val;
    logic                   zero_in;
    logic                   unused_z_bits;

    // Two guard bits let -(-2.0) and the gain growth fit without wrapping.
    assign x_ext   = IW'(x_in);
    assign y_ext   = IW'(y_in);
    assign zero_in = (x_in == '0) && (y_in == '0);

    // Fold the left half-plane onto x >= 0 so the micro-rotations always converge.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[W-1]) begin
            if (!y_in[W-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = HALF_PI_INT;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = -HALF_PI_INT;
            end
        end
    end

    cordic_atan_rom #(
        .W (W)
    ) u_rom (
        .idx      (iter_cnt),
        .atan_val (atan_val)
    );

    always_comb begin
        x_sh = x_r >>> iter_cnt;
        y_sh = y_r >>> iter_cnt;
        if (y_r[IW-1]) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_val;
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_val;
        end
    end

    assign unused_z_bits = z_nxt[IW-1] ^ z_nxt[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            iter_cnt  <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            zero_r    <= 1'b0;
            ready     <= 1'b1;
            done      <= 1'b0;
            angle     <= '0;
            magnitude <= '0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r      <= x_pre;
                        y_r      <= y_pre;
                        z_r      <= z_pre;
                        zero_r   <= zero_in;
                        iter_cnt <= '0;
                        ready    <= 1'b0;
                        state    <= ST_ITERATE;
                    end
                end
                ST_ITERATE: begin
                    x_r      <= x_nxt;
                    y_r      <= y_nxt;
                    z_r      <= z_nxt;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST) begin
                        // A zero vector never turns y negative, so z would drift; pin it to 0.
                        angle     <= zero_r ? '0 : z_nxt[W:1];
                        magnitude <= x_nxt;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
